mccoy_prog_feeder: RTL

Program store and instruction sequencer sitting directly upstream of the McCoy core. Holds a 64-word × 6-bit program, loaded one word per cycle over a simple valid/ready port. In run mode it returns the word addressed by the core's PC on the core's 6-bit instruction input (io_in[7:2]). It owns the core's reset and stops the core when the PC leaves the loaded program.

---
 rtl/mccoy_prog_feeder_pkg.sv | 25 ++
 rtl/mccoy_prog_feeder_if.sv | 31 +++
 rtl/mccoy_prog_mem.sv | 38 +++
 rtl/mccoy_prog_feeder.sv | 118 +++++++++++
 4 files changed

// File: rtl/mccoy_prog_feeder_pkg.sv
// ============================================================================
//  Module      : mccoy_feeder_pkg
//  Description : Shared types and defaults for the McCoy program feeder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mccoy_feeder_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 6;
    localparam int CYC_W_DEF  = 8;
    localparam logic [DATA_W_DEF-1:0] FILL_INSTR_DEF = 6'b000000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_PRIME = 3'd2,
        ST_RUN   = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mccoy_prog_feeder_if.sv
// ============================================================================
//  Module      : mccoy_prog_feeder_if
//  Description : Program-load handshake and core instruction port bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mccoy_prog_feeder_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 6
);
    logic              load_en;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic [ADDR_W-1:0] core_pc;
    logic [DATA_W-1:0] instr;
    logic              cpu_reset;

    modport master (
        output load_en, load_valid, load_data, core_pc,
        input  load_ready, instr, cpu_reset
    );

    modport slave (
        input  load_en, load_valid, load_data, core_pc,
        output load_ready, instr, cpu_reset
    );
endinterface

`default_nettype wire

// File: rtl/mccoy_prog_mem.sv
// ============================================================================
//  Module      : mccoy_prog_mem
//  Description : Register-array program store, async clear, comb read.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mccoy_prog_mem #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 6
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              we,
    input  wire logic [ADDR_W-1:0] waddr,
    input  wire logic [DATA_W-1:0] wdata,
    input  wire logic [ADDR_W-1:0] raddr,
    output logic      [DATA_W-1:0] rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/mccoy_prog_feeder.sv
// ============================================================================
//  Module      : mccoy_prog_feeder
//  Description : Program loader / instruction sequencer for the McCoy core.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mccoy_prog_feeder
    import mccoy_feeder_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                DATA_W     = DATA_W_DEF,
    parameter int                CYC_W      = CYC_W_DEF,
    parameter logic [DATA_W-1:0] FILL_INSTR = DATA_W'(FILL_INSTR_DEF)
) (
    input  wire logic              clk,
    input  wire logic              reset,
    mccoy_prog_feeder_if.slave     bus,
    output logic      [ADDR_W:0]   prog_len,
    output logic                   running,
    output logic                   done,
    output logic      [CYC_W-1:0]  run_cycles
);
    localparam logic [ADDR_W:0]  FULL    = (ADDR_W+1)'(1 << ADDR_W);
    localparam logic [CYC_W-1:0] CYC_MAX = '1;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   prog_len_q, prog_len_d;
    logic [CYC_W-1:0]  run_cycles_q, run_cycles_d;

    logic              load_ready;
    logic              in_range;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    assign load_ready = (state_q == ST_LOAD) && (wr_ptr_q < FULL);
    assign in_range   = {1'b0, bus.core_pc} < prog_len_q;
    // load_en low is the exit cycle, so a word presented then is dropped
    assign mem_we     = load_ready && bus.load_en && bus.load_valid;

    mccoy_prog_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .rst_n (reset),
        .we    (mem_we),
        .waddr (wr_ptr_q[ADDR_W-1:0]),
        .wdata (bus.load_data),
        .raddr (bus.core_pc),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        prog_len_d   = prog_len_q;
        run_cycles_d = run_cycles_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (bus.load_en) begin
                    state_d  = ST_LOAD;
                    wr_ptr_d = '0;
                end
            end
            ST_LOAD: begin
                if (!bus.load_en) begin
                    state_d    = ST_PRIME;
                    prog_len_d = wr_ptr_q;
                end else if (mem_we) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
            end
            ST_PRIME: begin
                state_d      = ST_RUN;
                run_cycles_d = '0;
            end
            ST_RUN: begin
                if (run_cycles_q != CYC_MAX) begin
                    run_cycles_d = run_cycles_q + 1'b1;
                end
                if (bus.load_en) begin
                    state_d  = ST_LOAD;
                    wr_ptr_d = '0;
                end else if (!in_range) begin
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            prog_len_q   <= '0;
            run_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            prog_len_q   <= prog_len_d;
            run_cycles_q <= run_cycles_d;
        end
    end

    assign bus.load_ready = load_ready;
    assign bus.instr      = (state_q == ST_RUN && in_range) ? mem_rdata : FILL_INSTR;
    assign bus.cpu_reset  = (state_q != ST_RUN);
    assign prog_len       = prog_len_q;
    assign running        = (state_q == ST_RUN);
    assign done           = (state_q == ST_HALT);
    assign run_cycles     = run_cycles_q;

endmodule

`default_nettype wire
